exeu_lsu: RTL and testbench

//  Load/store unit directly downstream of the EX-stage ALU: takes alu_out as the effective address.

---
 rtl/exeu_lsu_if.sv | 39 +++
 rtl/exeu_lsu.sv | 84 ++++++++
 tb/tb_exeu_lsu.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/exeu_lsu_if.sv
// exeu_lsu_if: EX-side request, memory request/response and writeback channels of the LSU.
interface exeu_lsu_if #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic [RD_W-1:0] in_rd;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_we;
    logic [XLEN-1:0] mem_req_addr;
    logic [63:0]     mem_req_wdata;
    logic [7:0]      mem_req_wmask;
    logic            mem_rsp_valid;
    logic [63:0]     mem_rsp_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic [RD_W-1:0] out_rd;
    logic            out_misalign;

    modport master (
        input  in_valid, in_op, in_addr, in_wdata, in_rd,
               mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
        output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               mem_req_wmask, out_valid, out_rdata, out_rd, out_misalign
    );

    modport slave (
        output in_valid, in_op, in_addr, in_wdata, in_rd,
               mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
        input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               mem_req_wmask, out_valid, out_rdata, out_rd, out_misalign
    );
endinterface

// File: rtl/exeu_lsu.sv
// exeu_lsu: single-outstanding load/store unit; aligned 64-bit memory access with lane shift and load extension.
module exeu_lsu #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input logic         clk,
    input logic         rst_n,
    input logic         flush,
    exeu_lsu_if.master  bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t          state, state_n;
    logic [3:0]      op_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [RD_W-1:0] rd_q;
    logic            mis_q;
    logic            mis_in, accept, store;
    logic [1:0]      sz;
    logic [2:0]      off;
    logic [63:0]     raw, ld;
    logic [7:0]      base;

    assign store  = op_q[3];
    assign sz     = op_q[1:0];
    assign off    = addr_q[2:0];
    assign mis_in = (bus.in_op[1:0] == 2'd1 && bus.in_addr[0]) ||
                    (bus.in_op[1:0] == 2'd2 && bus.in_addr[1:0] != 2'd0) ||
                    (bus.in_op[1:0] == 2'd3 && bus.in_addr[2:0] != 3'd0);
    assign accept = state == IDLE && bus.in_valid && !flush;
    assign raw    = bus.mem_rsp_rdata >> {off, 3'b000};
    assign ld     = sz == 2'd0 ? {{56{!op_q[2] && raw[7]}}, raw[7:0]} :
                    sz == 2'd1 ? {{48{!op_q[2] && raw[15]}}, raw[15:0]} :
                    sz == 2'd2 ? {{32{!op_q[2] && raw[31]}}, raw[31:0]} : raw;
    assign base   = sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0f : 8'hff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // A response racing a flush in WAIT is consumed there, so DRAIN is skipped.
    always_comb begin
        state_n           = state;
        bus.in_ready      = state == IDLE;
        bus.mem_req_valid = state == REQ;
        bus.mem_req_we    = state == REQ && store;
        bus.mem_req_addr  = state == REQ ? {addr_q[XLEN-1:3], 3'b000} : '0;
        bus.mem_req_wdata = state == REQ && store ? wdata_q << {off, 3'b000} : '0;
        bus.mem_req_wmask = state == REQ && store ? base << off : '0;
        bus.out_valid     = state == DONE;
        bus.out_rdata     = state == DONE ? rdata_q : '0;
        bus.out_rd        = state == DONE && !store ? rd_q : '0;
        bus.out_misalign  = state == DONE && mis_q;
        case (state)
            IDLE:    state_n = accept ? (mis_in ? DONE : REQ) : IDLE;
            REQ:     state_n = flush ? IDLE : bus.mem_req_ready ? WAIT : REQ;
            WAIT:    state_n = flush ? (bus.mem_rsp_valid ? IDLE : DRAIN) : bus.mem_rsp_valid ? DONE : WAIT;
            DONE:    state_n = flush || bus.out_ready ? IDLE : DONE;
            DRAIN:   state_n = bus.mem_rsp_valid ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            op_q    <= bus.in_op;
            addr_q  <= bus.in_addr;
            wdata_q <= bus.in_wdata;
            rd_q    <= bus.in_rd;
            mis_q   <= mis_in;
            rdata_q <= '0;
        end else if (state == WAIT && bus.mem_rsp_valid && !flush) begin
            rdata_q <= store ? '0 : ld;
        end
    end
endmodule

// File: tb/tb_exeu_lsu.sv
// tb_exeu_lsu: directed vector table plus hand-written flush/stall/reset sequences for exeu_lsu.
module tb_exeu_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    exeu_lsu_if #(.XLEN(64), .RD_W(5)) b ();
    exeu_lsu #(.XLEN(64), .RD_W(5)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rsp;
        logic [63:0] exp_rd;
        logic [63:0] exp_wd;
        logic [7:0]  exp_mask;
        logic        mis;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic do_op(input vec_t t, input logic [4:0] rd, input int hold);
        @(negedge clk);
        b.in_valid = 1'b1;
        b.in_op = t.op;
        b.in_addr = t.addr;
        b.in_wdata = t.wdata;
        b.in_rd = rd;
        b.out_ready = (hold == 0);
        b.mem_req_ready = 1'b1;
        @(negedge clk);
        b.in_valid = 1'b0;
        if (t.mis) begin
            chk("mis_valid", b.out_valid, 1);
            chk("mis_flag", b.out_misalign, 1);
            chk("mis_noreq", b.mem_req_valid, 0);
            chk("mis_rdata", b.out_rdata, t.exp_rd);
        end else begin
            chk("req_valid", b.mem_req_valid, 1);
            chk("req_addr", b.mem_req_addr, t.addr & ~64'h7);
            chk("req_we", b.mem_req_we, t.op[3]);
            chk("req_mask", b.mem_req_wmask, t.exp_mask);
            if (t.op[3]) chk("req_wdata", b.mem_req_wdata, t.exp_wd);
            @(negedge clk);
            chk("wait_noreq", b.mem_req_valid, 0);
            chk("wait_noout", b.out_valid, 0);
            b.mem_rsp_valid = 1'b1;
            b.mem_rsp_rdata = t.rsp;
            @(negedge clk);
            b.mem_rsp_valid = 1'b0;
            chk("out_valid", b.out_valid, 1);
            chk("out_rdata", b.out_rdata, t.exp_rd);
            chk("out_rd", b.out_rd, t.op[3] ? 5'd0 : rd);
            chk("out_mis", b.out_misalign, 0);
        end
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", b.out_valid, 1);
            chk("hold_rdata", b.out_rdata, t.exp_rd);
            chk("hold_inrdy", b.in_ready, 0);
        end
        b.out_ready = 1'b1;
        @(negedge clk);
        chk("end_valid", b.out_valid, 0);
        chk("end_inrdy", b.in_ready, 1);
    endtask

    initial begin
        v[0]  = '{4'b0011, 64'h1000, 64'h0, 64'h8877665544332211, 64'h8877665544332211, 64'h0, 8'h00, 1'b0};
        v[1]  = '{4'b0000, 64'h1003, 64'h0, 64'h11223344F0443322, 64'hFFFFFFFFFFFFFFF0, 64'h0, 8'h00, 1'b0};
        v[2]  = '{4'b0100, 64'h1003, 64'h0, 64'h11223344F0443322, 64'h00000000000000F0, 64'h0, 8'h00, 1'b0};
        v[3]  = '{4'b1001, 64'h1006, 64'hABCD, 64'h0, 64'h0, 64'hABCD000000000000, 8'hC0, 1'b0};
        v[4]  = '{4'b0010, 64'h1002, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 1'b1};
        v[5]  = '{4'b0001, 64'h1004, 64'h0, 64'h0000800100000000, 64'hFFFFFFFFFFFF8001, 64'h0, 8'h00, 1'b0};
        v[6]  = '{4'b0110, 64'h1004, 64'h0, 64'h89ABCDEF00000000, 64'h0000000089ABCDEF, 64'h0, 8'h00, 1'b0};
        v[7]  = '{4'b0010, 64'h1004, 64'h0, 64'h89ABCDEF00000000, 64'hFFFFFFFF89ABCDEF, 64'h0, 8'h00, 1'b0};
        v[8]  = '{4'b1000, 64'h1007, 64'hFFFFFFFFFFFFFF5A, 64'h0, 64'h0, 64'h5A00000000000000, 8'h80, 1'b0};
        v[9]  = '{4'b1010, 64'h1004, 64'h1234567899AABBCC, 64'h0, 64'h0, 64'h99AABBCC00000000, 8'hF0, 1'b0};
        v[10] = '{4'b1011, 64'h1008, 64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0123456789ABCDEF, 8'hFF, 1'b0};
        v[11] = '{4'b0111, 64'h1010, 64'h0, 64'hF00000000000000F, 64'hF00000000000000F, 64'h0, 8'h00, 1'b0};
        v[12] = '{4'b1011, 64'h100C, 64'h55, 64'h0, 64'h0, 64'h0, 8'h00, 1'b1};
        v[13] = '{4'b0001, 64'h1001, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 1'b1};
        v[14] = '{4'b0000, 64'h1007, 64'h0, 64'h7F00000000000000, 64'h000000000000007F, 64'h0, 8'h00, 1'b0};
        v[15] = '{4'b1000, 64'h1000, 64'h00000000000000AB, 64'h0, 64'h0, 64'h00000000000000AB, 8'h01, 1'b0};

        b.in_valid = 0; b.in_op = 0; b.in_addr = 0; b.in_wdata = 0; b.in_rd = 0;
        b.mem_req_ready = 0; b.mem_rsp_valid = 0; b.mem_rsp_rdata = 0; b.out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_inrdy", b.in_ready, 1);
        chk("rst_reqv", b.mem_req_valid, 0);
        chk("rst_outv", b.out_valid, 0);
        chk("rst_rdata", b.out_rdata, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) do_op(v[i], 5'(i + 1), 0);

        // request stalled three cycles, then flushed while waiting for the response
        @(negedge clk);
        b.in_valid = 1; b.in_op = 4'b0011; b.in_addr = 64'h2000; b.mem_req_ready = 0;
        @(negedge clk);
        b.in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_reqv", b.mem_req_valid, 1);
            chk("stall_addr", b.mem_req_addr, 64'h2000);
            @(negedge clk);
        end
        chk("stall_reqv", b.mem_req_valid, 1);
        b.mem_req_ready = 1;
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("drain_outv", b.out_valid, 0);
        chk("drain_inrdy", b.in_ready, 0);
        chk("drain_reqv", b.mem_req_valid, 0);
        b.mem_rsp_valid = 1; b.mem_rsp_rdata = 64'hDEADBEEFDEADBEEF;
        @(negedge clk);
        b.mem_rsp_valid = 0;
        chk("drained_outv", b.out_valid, 0);
        chk("drained_inrdy", b.in_ready, 1);
        do_op(v[0], 5'd7, 0);

        do_op(v[1], 5'd9, 4);

        // flush while result is waiting for writeback
        @(negedge clk);
        b.in_valid = 1; b.in_op = 4'b0010; b.in_addr = 64'h1002; b.out_ready = 0;
        @(negedge clk);
        b.in_valid = 0;
        chk("fdone_outv", b.out_valid, 1);
        flush = 1;
        @(negedge clk);
        flush = 0; b.out_ready = 1;
        chk("fdone_outv2", b.out_valid, 0);
        chk("fdone_inrdy", b.in_ready, 1);

        // flush beats in_valid in IDLE
        @(negedge clk);
        b.in_valid = 1; b.in_op = 4'b0011; b.in_addr = 64'h3000; flush = 1;
        @(negedge clk);
        b.in_valid = 0; flush = 0;
        chk("fidle_inrdy", b.in_ready, 1);
        chk("fidle_reqv", b.mem_req_valid, 0);

        // flush before the request handshake
        @(negedge clk);
        b.in_valid = 1; b.mem_req_ready = 0;
        @(negedge clk);
        b.in_valid = 0;
        chk("freq_reqv", b.mem_req_valid, 1);
        flush = 1;
        @(negedge clk);
        flush = 0; b.mem_req_ready = 1;
        chk("freq_reqv2", b.mem_req_valid, 0);
        chk("freq_inrdy", b.in_ready, 1);

        // response and flush together in WAIT
        @(negedge clk);
        b.in_valid = 1;
        @(negedge clk);
        b.in_valid = 0;
        @(negedge clk);
        flush = 1; b.mem_rsp_valid = 1;
        @(negedge clk);
        flush = 0; b.mem_rsp_valid = 0;
        chk("frsp_inrdy", b.in_ready, 1);
        chk("frsp_outv", b.out_valid, 0);
        @(negedge clk);
        chk("frsp_outv2", b.out_valid, 0);

        // asynchronous reset mid-request
        @(negedge clk);
        b.in_valid = 1; b.mem_req_ready = 0;
        @(negedge clk);
        b.in_valid = 0;
        chk("arst_pre", b.mem_req_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_reqv", b.mem_req_valid, 0);
        chk("arst_inrdy", b.in_ready, 1);
        #1 rst_n = 1;
        b.mem_req_ready = 1;
        do_op(v[5], 5'd3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
